led7seg_scan: RTL and testbench

Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display. Holds a packed hex/BCD value, cycles through digits at a programmable slot rate, and presents one 4-bit nibble at a time to the downstream 7-segment decoder while driving the matching active-low anode line. New values are staged on a load strobe and committed only at a frame boundary, so a frame never shows mixed old and new digits. Anti-ghosting blanking is applied at the start of every slot.

---
 rtl/led7seg_pkg.sv | 15 +
 rtl/led7seg_prescaler.sv | 25 ++
 rtl/led7seg_scan.sv | 145 ++++++++++++++
 tb/tb_led7seg_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led7seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
// AN_OFF is sized for the widest supported display; users slice it to NDIG.
package led7seg_pkg;

  localparam int NIB_W   = 4;
  localparam int MAX_DIG = 8;

  localparam logic [MAX_DIG-1:0] AN_OFF = '1;

  // A single-digit index still needs one bit to stay a legal vector.
  function automatic int idx_width(input int ndig);
    return (ndig < 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/led7seg_prescaler.sv
// Free-running slot prescaler: counts 0..PRESCALE-1, flags the last cycle of
// each slot so the scanner can advance on the following edge.
module led7seg_prescaler #(
  parameter int PRESCALE = 50000,
  parameter int CNT_W    = $clog2(PRESCALE)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed NDIG-digit common-anode scanner with frame-aligned commit
// of staged values and per-slot anti-ghosting blanking.
module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NIB_W*NDIG-1:0] value,
  input  logic [NDIG-1:0]       blank_mask,
  output logic [NIB_W-1:0]      digit,
  output logic [NDIG-1:0]       an,
  output logic                  load_ack,
  output logic                  frame_tick
);

  localparam int IDX_W = idx_width(NDIG);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam int VAL_W = NIB_W * NDIG;

  localparam logic [NDIG-1:0] AN_IDLE = AN_OFF[NDIG-1:0];

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_nx;
  logic             tc_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [IDX_W-1:0] idx_nx;
  logic             wrap;
  logic             commit;

  logic [VAL_W-1:0] staged;
  logic [NDIG-1:0]  staged_mask;
  logic             pending;
  logic [VAL_W-1:0] shadow;
  logic [NDIG-1:0]  shadow_mask;
  logic [VAL_W-1:0] shadow_nx;
  logic [NDIG-1:0]  shadow_mask_nx;

  logic [NIB_W-1:0] digit_nx;
  logic [NDIG-1:0]  an_nx;
  logic             lit_nx;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [VAL_W-1:0] v,
                                               input logic [IDX_W-1:0] k);
    return v[NIB_W*int'(k) +: NIB_W];
  endfunction

  function automatic logic [NDIG-1:0] anode_sel(input logic [IDX_W-1:0] k,
                                                input logic [NDIG-1:0]  m,
                                                input logic             lit);
    logic [NDIG-1:0] a;
    a = AN_IDLE;
    if (lit && !m[k]) begin
      a[k] = 1'b0;
    end
    return a;
  endfunction

  led7seg_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .count (cnt_p0),
    .tc    (tc_p0)
  );

  // Stage 0: slot/frame sequencing and next-cycle view of the display state
  assign wrap   = tc_p0 && (idx_p0 == IDX_W'(NDIG - 1));
  assign commit = wrap && pending;
  assign cnt_nx = tc_p0 ? '0 : cnt_p0 + 1'b1;

  always_comb begin
    idx_nx = idx_p0;
    if (tc_p0) begin
      idx_nx = wrap ? '0 : idx_p0 + 1'b1;
    end
  end

  assign shadow_nx      = commit ? staged : shadow;
  assign shadow_mask_nx = commit ? staged_mask : shadow_mask;

  // Outputs are computed from the next cycle's count/idx/shadow so that the
  // registered an/digit line up exactly with the slot they describe.
  assign lit_nx   = (int'(cnt_nx) >= BLANK_CYC);
  assign digit_nx = nib_sel(shadow_nx, idx_nx);
  assign an_nx    = anode_sel(idx_nx, shadow_mask_nx, lit_nx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p0 <= '0;
    end else begin
      idx_p0 <= idx_nx;
    end
  end

  // A load coinciding with a commit wins pending: the old staged value is
  // committed this edge and the new one waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged      <= '0;
      staged_mask <= '0;
      pending     <= 1'b0;
    end else if (load) begin
      staged      <= value;
      staged_mask <= blank_mask;
      pending     <= 1'b1;
    end else if (commit) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      shadow_mask <= '0;
    end else begin
      shadow      <= shadow_nx;
      shadow_mask <= shadow_mask_nx;
    end
  end

  // Stage 1: registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit      <= '0;
      an         <= AN_IDLE;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (tc_p0) begin
        digit <= digit_nx;
      end
      an         <= an_nx;
      load_ack   <= commit;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_led7seg_scan.sv
// Self-checking bench for led7seg_scan: directed table, corner sequences and
// randomized loads against a time-indexed reference model.
module tb_led7seg_scan;

  localparam int NDIG      = 4;
  localparam int PRESCALE  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = NDIG * PRESCALE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        load_ack;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int ack_cnt = 0;
  int last_ack_t = -1;
  int ack_gap = 0;

  // reference model: what is on display, what is waiting, and when
  logic [15:0] m_shadow, m_staged;
  logic [3:0]  m_smask, m_stmask;
  logic        m_pending, m_ack;

  led7seg_scan #(
    .NDIG      (NDIG),
    .PRESCALE  (PRESCALE),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .digit      (digit),
    .an         (an),
    .load_ack   (load_ack),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d actual=running required=finished", t);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ld;
    logic [15:0] v;
    logic [3:0]  an;
    logic [3:0]  dg;
    logic        ft;
    logic        ack;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_shadow = '0; m_staged = '0; m_smask = '0; m_stmask = '0;
    m_pending = 1'b0; m_ack = 1'b0;
  endtask

  task automatic compare_model();
    int slot, ph;
    logic [3:0] exp_an;
    logic [3:0] exp_dg;
    slot = (t / PRESCALE) % NDIG;
    ph   = t % PRESCALE;
    exp_an = 4'hF;
    if (ph >= BLANK_CYC && !m_smask[slot]) exp_an[slot] = 1'b0;
    exp_dg = 4'((m_shadow >> (4 * slot)) & 16'hF);
    chk("an", an, exp_an);
    chk("digit", digit, exp_dg);
    chk("frame_tick", frame_tick, (t > 0 && t % FRAME == 0));
    chk("load_ack", load_ack, m_ack);
  endtask

  task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] m);
    load = ld; value = v; blank_mask = m;
    @(posedge clk);
    t++;
    m_ack = 1'b0;
    if (t % FRAME == 0 && m_pending) begin
      m_shadow = m_staged; m_smask = m_stmask; m_pending = 1'b0; m_ack = 1'b1;
    end
    if (ld) begin
      m_staged = v; m_stmask = m; m_pending = 1'b1;
    end
    #1;
    load = 1'b0;
    compare_model();
    if (load_ack === 1'b1) begin
      ack_gap = t - last_ack_t;
      last_ack_t = t;
      ack_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 4'h0);
  endtask

  task automatic run_to_frame();
    for (int i = 0; i < FRAME && (t % FRAME) != 0; i++) tick(1'b0, 16'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_digit", digit, 4'h0);
    chk("rst_ack", load_ack, 1'b0);
    chk("rst_ft", frame_tick, 1'b0);
    @(negedge clk);
    load = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    compare_model();
  endtask

  initial begin
    int a0, cnt_e, cnt_b, cnt_bad_an, cnt_bad_dg;
    logic        rl;
    logic [15:0] rv;
    logic [3:0]  rm;

    // index i holds the expectations after edge i+1; load 0x4321 mid-frame
    tbl[0]  = '{1'b0, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 4'hE, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 4'hD, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h4321, 4'hD, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 4'hD, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 4'hB, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 4'hB, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 4'hB, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 16'h0000, 4'hF, 4'h1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 16'h0000, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 16'h0000, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 16'h0000, 4'hE, 4'h1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 16'h0000, 4'hF, 4'h2, 1'b0, 1'b0};

    model_reset();
    do_reset();

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].ld, tbl[i].v, 4'h0);
      chk("tbl_an", an, tbl[i].an);
      chk("tbl_digit", digit, tbl[i].dg);
      chk("tbl_ft", frame_tick, tbl[i].ft);
      chk("tbl_ack", load_ack, tbl[i].ack);
    end

    // two loads in one frame: only the last one shows, one ack
    a0 = ack_cnt;
    tick(1'b1, 16'h1111, 4'h0);
    run(3);
    tick(1'b1, 16'h9876, 4'h0);
    run_to_frame();
    chk("two_loads_digit0", digit, 4'h6);
    chk("two_loads_ack", load_ack, 1'b1);
    run(FRAME);
    chk("two_loads_repeat", digit, 4'h6);
    chk("two_loads_ack_count", ack_cnt - a0, 1);

    // load on the exact commit edge while 0x1234 is pending
    tick(1'b1, 16'h1234, 4'h0);
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) tick(1'b0, 16'h0, 4'h0);
    a0 = ack_cnt;
    tick(1'b1, 16'hABCD, 4'h0);
    chk("commit_edge_old_digit", digit, 4'h4);
    chk("commit_edge_ack1", load_ack, 1'b1);
    run(FRAME);
    chk("commit_edge_new_digit", digit, 4'hD);
    chk("commit_edge_ack2", load_ack, 1'b1);
    chk("commit_edge_ack_count", ack_cnt - a0, 2);
    chk("commit_edge_ack_gap", ack_gap, FRAME);

    // blank mask 1010 with 0x5555 across one full frame
    tick(1'b1, 16'h5555, 4'b1010);
    run_to_frame();
    cnt_e = 0; cnt_b = 0; cnt_bad_an = 0; cnt_bad_dg = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b0, 16'h0, 4'h0);
      if (an === 4'hE) cnt_e++;
      if (an === 4'hB) cnt_b++;
      if (an[1] !== 1'b1 || an[3] !== 1'b1) cnt_bad_an++;
      if (digit !== 4'h5) cnt_bad_dg++;
    end
    chk("mask_digit0_lit", cnt_e, 3);
    chk("mask_digit2_lit", cnt_b, 3);
    chk("mask_dark_digits", cnt_bad_an, 0);
    chk("mask_digit_seq", cnt_bad_dg, 0);

    // reset mid-slot with a load pending
    tick(1'b1, 16'h7777, 4'h0);
    run(2);
    a0 = ack_cnt;
    do_reset();
    run(40);
    chk("rst_pending_no_ack", ack_cnt - a0, 0);

    // randomized loads with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      rl = ($urandom_range(0, 7) == 0);
      rv = 16'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick(rl, rv, rm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
